buyruk_ffram_denetleyici: RTL and testbench
===========================================

# buyruk_ffram_denetleyici

Controller sitting in front of the 512×41-bit instruction flip-flop RAM (byte-lane write enables, combinational read). It shares the RAM between the core fetch path and the program loader, and sweeps the whole array to zero after reset and on `flush_i`. Bit 40 of every row is the row-valid tag; bits 39:0 hold instruction data. Fetch responses are registered, giving one-cycle fetch latency.

## Interface
Parameters:
- `ROWS`, 512: number of RAM rows. Must equal 2^`ADR_W`.
- `ADR_W`, 9: row address width.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `flush_i` in 1: invalidate-all request; starts a sweep.
- `busy_o` out 1: a sweep is in progress.
- `fetch_req_i` in 1: fetch request.
- `fetch_adr_i` in ADR_W: fetch row address.
- `fetch_gnt_o` out 1: fetch accepted this cycle.
- `fetch_rvalid_o` out 1: fetch response valid (one cycle after grant).
- `fetch_data_o` out 40: row bits 39:0.
- `fetch_hit_o` out 1: row bit 40 (valid tag).
- `ld_req_i` in 1: loader write request.
- `ld_adr_i` in ADR_W: loader row address.
- `ld_data_i` in 40: loader write data.
- `ld_be_i` in 5: loader byte-lane enables; lane 4 also writes bit 40 = 1.
- `ld_gnt_o` out 1: loader write performed this cycle.
- `ram_wen_o` out 5: to RAM `wen_i`.
- `ram_wdata_o` out 41: to RAM `data_i`.
- `ram_wadr_o` out ADR_W: to RAM `wadr_i`.
- `ram_radr_o` out ADR_W: to RAM `radr_i`.
- `ram_rdata_i` in 41: from RAM `data_o`.

## Operation
- The controller has two states: SWEEP and RUN. Reset enters SWEEP with the sweep counter at 0.
- **SWEEP**
  - Each cycle: `ram_wen_o`=5'b11111, `ram_wdata_o`=0, `ram_wadr_o`=counter; the counter then increments.
  - The cycle that writes row ROWS-1 is the last sweep cycle; the next cycle is RUN.
  - `busy_o`=1 in SWEEP, so a sweep takes exactly ROWS cycles.
  - `fetch_gnt_o`=0 and `ld_gnt_o`=0 throughout.
- **RUN**
  - `busy_o`=0.
  - Loader:
    - `ld_gnt_o` = `ld_req_i` & ~`flush_i`.
    - On grant: `ram_wen_o`=`ld_be_i`, `ram_wadr_o`=`ld_adr_i`, `ram_wdata_o`={1'b1, `ld_data_i`}.
    - With no grant, `ram_wen_o`=0.
  - Fetch:
    - `ram_radr_o`=`fetch_adr_i` at all times.
    - `fetch_gnt_o` = `fetch_req_i` & ~`flush_i` & ~(`ld_gnt_o` & `ld_adr_i`==`fetch_adr_i`).
    - A fetch to the row being written in the same cycle is stalled. The requester holds its request and is granted the following cycle with the new data.
  - Fetch and loader to different rows are both granted in the same cycle.
- **Flush**
  - `flush_i`=1 in RUN → next cycle SWEEP with counter 0. No grants are given in the `flush_i` cycle.
  - `flush_i`=1 during SWEEP restarts the counter at 0 on the next cycle.
- **Response register**
  - On a fetch grant, the next posedge loads `fetch_data_o`=`ram_rdata_i`[39:0], `fetch_hit_o`=`ram_rdata_i`[40], `fetch_rvalid_o`=1.
  - Otherwise `fetch_rvalid_o`=0 and the data/hit registers hold their values.
- **Reset mid-operation:** an asynchronous `rst_ni` low immediately forces SWEEP, counter 0, and all response registers to 0. Any in-flight fetch response is discarded.

## Timing
- **Output values during reset:**
  - `busy_o`=1.
  - `fetch_rvalid_o`, `fetch_data_o`, `fetch_hit_o` = 0.
  - Grants = 0.
  - `ram_wen_o`=5'b11111 and `ram_wadr_o`=0, since the sweep starts at reset.
- **Sweep duration:** after `rst_ni` rises, the first edge writes row 0. `busy_o` falls after edge 512, and the first grant is possible in cycle 513.
- **Fetch latency:** grant in cycle N → `fetch_rvalid_o` and data in cycle N+1. Back-to-back grants give one response per cycle.
- **Loader write timing:** the write commits at the posedge ending the grant cycle. A fetch to that row granted in the next cycle returns the new data.
- **Grant paths:** all grants are combinational from the request inputs and the state. There are no combinational paths from `ram_rdata_i` to any output.

## Test plan
- **Reset sweep:** preload the RAM with 0xFF rows, then release reset. `busy_o` stays high exactly 512 cycles; afterwards a fetch of rows 0, 255 and 511 returns data 0, hit 0.
- **Loader write then fetch:** write row 5 = 40'h12_3456_789A with be=5'b11111, then fetch row 5. `rvalid` comes one cycle after grant with data 40'h12_3456_789A, hit 1.
- **Partial write:** write row 7 with be=5'b00001 and data 0xAB. The fetch returns data 40'h00_0000_00AB, hit 0.
- **Same-address collision:** loader and fetch both target row 9 in one cycle. `ld_gnt_o`=1 and `fetch_gnt_o`=0; the next cycle the fetch is granted and returns the new data. A collision on different rows gives both grants.
- **Flush:** pulse `flush_i` while `ld_req_i` is high. No grant in that cycle, `busy_o`=1 for 512 cycles, and all previously written rows then read hit 0.
- **Reset mid-sweep:** assert `rst_ni` low at sweep row 300. The outputs go to reset values immediately, and the sweep restarts at row 0 for a full 512 cycles.

Source files
------------

// File: rtl/buyruk_ffram_denetleyici.sv
// buyruk_ffram_denetleyici
// ------------------------
// Controller in front of the 512x41 instruction flip-flop RAM. Bit 40 of each
// row is the row-valid tag and bits 39:0 hold instruction data.
//
// The controller arbitrates RAM access between the core fetch path and the
// program loader. After reset, and whenever flush_i is raised, it zeroes the
// whole array with a sweep that writes one row per cycle.
//
// Ports
//   clk_i, rst_ni         clock and asynchronous active-low reset
//   flush_i               invalidate-all request (restarts the sweep)
//   busy_o                sweep in progress
//   fetch_req_i/adr_i     fetch request and row address
//   fetch_gnt_o           fetch accepted this cycle
//   fetch_rvalid_o        registered response, one cycle after the grant
//   fetch_data_o/hit_o    row bits 39:0 and row bit 40
//   ld_req_i/adr_i/data_i loader write request
//   ld_be_i               loader byte-lane enables (lane 4 also sets the tag)
//   ld_gnt_o              loader write performed this cycle
//   ram_*                 RAM write port, read address and read data
module buyruk_ffram_denetleyici #(
  parameter int ROWS  = 512,
  parameter int ADR_W = 9
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  output logic             busy_o,
  input  logic             fetch_req_i,
  input  logic [ADR_W-1:0] fetch_adr_i,
  output logic             fetch_gnt_o,
  output logic             fetch_rvalid_o,
  output logic [39:0]      fetch_data_o,
  output logic             fetch_hit_o,
  input  logic             ld_req_i,
  input  logic [ADR_W-1:0] ld_adr_i,
  input  logic [39:0]      ld_data_i,
  input  logic [4:0]       ld_be_i,
  output logic             ld_gnt_o,
  output logic [4:0]       ram_wen_o,
  output logic [40:0]      ram_wdata_o,
  output logic [ADR_W-1:0] ram_wadr_o,
  output logic [ADR_W-1:0] ram_radr_o,
  input  logic [40:0]      ram_rdata_i
);

  typedef enum logic {
    ST_SWEEP = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam logic [ADR_W-1:0] LAST_ROW = ADR_W'(ROWS - 1);

  state_t           state_reg, state_next;
  logic [ADR_W-1:0] cnt_reg, cnt_next;

  logic             rvalid_reg;
  logic [39:0]      data_reg;
  logic             hit_reg;

  logic             ld_gnt;
  logic             fetch_gnt;

  // State and sweep counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= ST_SWEEP;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next state, grants and the RAM write port
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    busy_o      = 1'b0;
    ld_gnt      = 1'b0;
    fetch_gnt   = 1'b0;
    ram_wen_o   = 5'b00000;
    ram_wdata_o = '0;
    ram_wadr_o  = ld_adr_i;

    case (state_reg)
      ST_SWEEP: begin
        busy_o      = 1'b1;
        ram_wen_o   = 5'b11111;
        ram_wdata_o = '0;
        ram_wadr_o  = cnt_reg;
        if (flush_i) begin
          // A new flush restarts the sweep from row 0.
          cnt_next = '0;
        end else if (cnt_reg == LAST_ROW) begin
          state_next = ST_RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      ST_RUN: begin
        if (flush_i) begin
          state_next = ST_SWEEP;
          cnt_next   = '0;
        end else begin
          ld_gnt = ld_req_i;
          // The RAM read is combinational, so a fetch of the row being
          // written this cycle would return stale data. It is stalled and
          // granted on the next cycle, once the write has committed.
          fetch_gnt = fetch_req_i & ~(ld_gnt & (ld_adr_i == fetch_adr_i));
          if (ld_gnt) begin
            ram_wen_o   = ld_be_i;
            ram_wdata_o = {1'b1, ld_data_i};
          end
        end
      end

      default: begin
        state_next = ST_SWEEP;
        cnt_next   = '0;
      end
    endcase
  end

  assign ld_gnt_o    = ld_gnt;
  assign fetch_gnt_o = fetch_gnt;
  assign ram_radr_o  = fetch_adr_i;

  // Fetch response register. Data and hit hold between responses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_reg <= 1'b0;
      data_reg   <= '0;
      hit_reg    <= 1'b0;
    end else begin
      rvalid_reg <= fetch_gnt;
      if (fetch_gnt) begin
        data_reg <= ram_rdata_i[39:0];
        hit_reg  <= ram_rdata_i[40];
      end
    end
  end

  assign fetch_rvalid_o = rvalid_reg;
  assign fetch_data_o   = data_reg;
  assign fetch_hit_o    = hit_reg;

endmodule

// File: tb/tb_buyruk_ffram_denetleyici.sv
// Testbench for buyruk_ffram_denetleyici. It contains a behavioural model of
// the 512x41 flip-flop RAM with byte-lane writes and a combinational read.
// Directed stimulus pushes the expected fetch responses into a scoreboard
// queue, and a separate monitor pops and compares them on every rvalid.
module tb_buyruk_ffram_denetleyici;

  localparam int ROWS  = 512;
  localparam int ADR_W = 9;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             flush_i;
  logic             busy_o;
  logic             fetch_req_i;
  logic [ADR_W-1:0] fetch_adr_i;
  logic             fetch_gnt_o;
  logic             fetch_rvalid_o;
  logic [39:0]      fetch_data_o;
  logic             fetch_hit_o;
  logic             ld_req_i;
  logic [ADR_W-1:0] ld_adr_i;
  logic [39:0]      ld_data_i;
  logic [4:0]       ld_be_i;
  logic             ld_gnt_o;
  logic [4:0]       ram_wen_o;
  logic [40:0]      ram_wdata_o;
  logic [ADR_W-1:0] ram_wadr_o;
  logic [ADR_W-1:0] ram_radr_o;
  logic [40:0]      ram_rdata_i;

  buyruk_ffram_denetleyici #(.ROWS(ROWS), .ADR_W(ADR_W)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .busy_o         (busy_o),
    .fetch_req_i    (fetch_req_i),
    .fetch_adr_i    (fetch_adr_i),
    .fetch_gnt_o    (fetch_gnt_o),
    .fetch_rvalid_o (fetch_rvalid_o),
    .fetch_data_o   (fetch_data_o),
    .fetch_hit_o    (fetch_hit_o),
    .ld_req_i       (ld_req_i),
    .ld_adr_i       (ld_adr_i),
    .ld_data_i      (ld_data_i),
    .ld_be_i        (ld_be_i),
    .ld_gnt_o       (ld_gnt_o),
    .ram_wen_o      (ram_wen_o),
    .ram_wdata_o    (ram_wdata_o),
    .ram_wadr_o     (ram_wadr_o),
    .ram_radr_o     (ram_radr_o),
    .ram_rdata_i    (ram_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // RAM model: lanes 0..3 cover bits 8i+7:8i, and lane 4 covers bits 40:32.
  logic [40:0] mem [ROWS];
  logic        preload;

  always @(posedge clk_i) begin
    if (preload) begin
      for (int r = 0; r < ROWS; r++) mem[r] <= '1;
    end else begin
      for (int l = 0; l < 4; l++)
        if (ram_wen_o[l]) mem[ram_wadr_o][8*l +: 8] <= ram_wdata_o[8*l +: 8];
      if (ram_wen_o[4]) mem[ram_wadr_o][40:32] <= ram_wdata_o[40:32];
    end
  end
  assign ram_rdata_i = mem[ram_radr_o];

  // Cycle stamp used to check the one-cycle response latency
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    logic [39:0] data;
    logic        hit;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  task automatic push_exp(input logic [39:0] d, input logic h);
    exp_t e;
    e.data = d;
    e.hit  = h;
    e.cyc  = cyc + 1;
    sb.push_back(e);
  endtask

  // Monitor: one line per response
  always @(negedge clk_i) begin
    if (rst_ni && fetch_rvalid_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_rvalid", 64'(fetch_rvalid_o), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("resp cyc=%0d data=%010h hit=%0b (exp %010h/%0b)",
                 cyc, fetch_data_o, fetch_hit_o, e.data, e.hit);
        chk("resp_data", 64'(fetch_data_o), 64'(e.data));
        chk("resp_hit", 64'(fetch_hit_o), 64'(e.hit));
        chk("resp_latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic fetch_one(input logic [ADR_W-1:0] adr, input logic [39:0] d, input logic h);
    bit got = 0;
    @(posedge clk_i); #1;
    fetch_req_i = 1'b1;
    fetch_adr_i = adr;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_i);
      if (fetch_gnt_o) begin
        got = 1;
        push_exp(d, h);
        $display("fetch row=%0d granted cyc=%0d", adr, cyc);
        break;
      end
      @(posedge clk_i); #1;
    end
    if (!got) chk("fetch_grant_timeout", 64'd0, 64'd1);
    @(posedge clk_i); #1;
    fetch_req_i = 1'b0;
  endtask

  task automatic ld_write(input logic [ADR_W-1:0] adr, input logic [39:0] d, input logic [4:0] be);
    @(posedge clk_i); #1;
    ld_req_i  = 1'b1;
    ld_adr_i  = adr;
    ld_data_i = d;
    ld_be_i   = be;
    @(negedge clk_i);
    $display("load row=%0d data=%010h be=%05b gnt=%0b", adr, d, be, ld_gnt_o);
    chk("ld_gnt", 64'(ld_gnt_o), 64'd1);
    @(posedge clk_i); #1;
    ld_req_i = 1'b0;
  endtask

  // Counts the consecutive negedge samples that have busy_o high
  task automatic count_busy(input string name);
    int n = 0;
    @(negedge clk_i);
    while (busy_o && n < 2000) begin
      n++;
      @(negedge clk_i);
    end
    $display("sweep %s busy cycles=%0d", name, n);
    chk(name, 64'(n), 64'd512);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni      = 1'b0;
    preload     = 1'b1;
    flush_i     = 1'b0;
    fetch_req_i = 1'b1;
    fetch_adr_i = '0;
    ld_req_i    = 1'b1;
    ld_adr_i    = '0;
    ld_data_i   = '0;
    ld_be_i     = 5'b11111;

    // Outputs while in reset, with requests asserted
    #2;
    chk("rst_busy", 64'(busy_o), 64'd1);
    chk("rst_wen", 64'(ram_wen_o), 64'h1f);
    chk("rst_wadr", 64'(ram_wadr_o), 64'd0);
    chk("rst_fetch_gnt", 64'(fetch_gnt_o), 64'd0);
    chk("rst_ld_gnt", 64'(ld_gnt_o), 64'd0);
    chk("rst_rvalid", 64'(fetch_rvalid_o), 64'd0);
    chk("rst_data", 64'(fetch_data_o), 64'd0);
    chk("rst_hit", 64'(fetch_hit_o), 64'd0);

    // The posedge at t=5 fills the RAM with ones. Reset is released after it.
    #5;
    preload     = 1'b0;
    rst_ni      = 1'b1;
    fetch_req_i = 1'b0;
    ld_req_i    = 1'b0;
    count_busy("reset_sweep_len");
    fetch_one(9'd0, 40'h0, 1'b0);
    fetch_one(9'd255, 40'h0, 1'b0);
    fetch_one(9'd511, 40'h0, 1'b0);

    // Full write, then a partial write with only lane 0 enabled
    ld_write(9'd5, 40'h12_3456_789A, 5'b11111);
    fetch_one(9'd5, 40'h12_3456_789A, 1'b1);
    ld_write(9'd7, 40'hFF_FFFF_FFAB, 5'b00001);
    fetch_one(9'd7, 40'h00_0000_00AB, 1'b0);

    // Collision on the same row: loader wins, fetch follows with new data
    @(posedge clk_i); #1;
    ld_req_i = 1'b1; ld_adr_i = 9'd9; ld_data_i = 40'hCA_FE00_BEEF; ld_be_i = 5'b11111;
    fetch_req_i = 1'b1; fetch_adr_i = 9'd9;
    @(negedge clk_i);
    $display("collision same row ld_gnt=%0b fetch_gnt=%0b", ld_gnt_o, fetch_gnt_o);
    chk("coll_ld_gnt", 64'(ld_gnt_o), 64'd1);
    chk("coll_fetch_stall", 64'(fetch_gnt_o), 64'd0);
    @(posedge clk_i); #1;
    ld_req_i = 1'b0;
    @(negedge clk_i);
    chk("coll_fetch_next", 64'(fetch_gnt_o), 64'd1);
    if (fetch_gnt_o) push_exp(40'hCA_FE00_BEEF, 1'b1);
    @(posedge clk_i); #1;
    fetch_req_i = 1'b0;

    // Loader and fetch on different rows: both granted
    @(posedge clk_i); #1;
    ld_req_i = 1'b1; ld_adr_i = 9'd10; ld_data_i = 40'h11_2233_4455; ld_be_i = 5'b11111;
    fetch_req_i = 1'b1; fetch_adr_i = 9'd5;
    @(negedge clk_i);
    $display("diff rows ld_gnt=%0b fetch_gnt=%0b", ld_gnt_o, fetch_gnt_o);
    chk("diff_ld_gnt", 64'(ld_gnt_o), 64'd1);
    chk("diff_fetch_gnt", 64'(fetch_gnt_o), 64'd1);
    if (fetch_gnt_o) push_exp(40'h12_3456_789A, 1'b1);
    @(posedge clk_i); #1;
    ld_req_i = 1'b0;

    // Back-to-back fetches, one response per cycle
    fetch_adr_i = 9'd10;
    @(negedge clk_i);
    chk("b2b_gnt0", 64'(fetch_gnt_o), 64'd1);
    if (fetch_gnt_o) push_exp(40'h11_2233_4455, 1'b1);
    @(posedge clk_i); #1;
    fetch_adr_i = 9'd9;
    @(negedge clk_i);
    chk("b2b_gnt1", 64'(fetch_gnt_o), 64'd1);
    if (fetch_gnt_o) push_exp(40'hCA_FE00_BEEF, 1'b1);
    @(posedge clk_i); #1;
    fetch_req_i = 1'b0;

    // Flush with loader and fetch requests pending
    @(posedge clk_i); #1;
    ld_req_i = 1'b1; ld_adr_i = 9'd11; ld_data_i = 40'h99_9999_9999;
    fetch_req_i = 1'b1; fetch_adr_i = 9'd3;
    flush_i = 1'b1;
    @(negedge clk_i);
    $display("flush cycle ld_gnt=%0b fetch_gnt=%0b", ld_gnt_o, fetch_gnt_o);
    chk("flush_ld_gnt", 64'(ld_gnt_o), 64'd0);
    chk("flush_fetch_gnt", 64'(fetch_gnt_o), 64'd0);
    @(posedge clk_i); #1;
    flush_i = 1'b0; ld_req_i = 1'b0; fetch_req_i = 1'b0;
    count_busy("flush_sweep_len");
    fetch_one(9'd5, 40'h0, 1'b0);
    fetch_one(9'd7, 40'h0, 1'b0);
    fetch_one(9'd9, 40'h0, 1'b0);
    fetch_one(9'd10, 40'h0, 1'b0);
    fetch_one(9'd11, 40'h0, 1'b0);

    // Leave nonzero response data behind, then reset in the middle of a sweep
    ld_write(9'd20, 40'h55_AAAA_5555, 5'b11111);
    fetch_one(9'd20, 40'h55_AAAA_5555, 1'b1);
    @(posedge clk_i); #1;
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    begin
      int k = 0;
      @(negedge clk_i);
      while (ram_wadr_o != 9'd300 && k < 1000) begin
        k++;
        @(negedge clk_i);
      end
      chk("reach_row300", 64'(ram_wadr_o), 64'd300);
    end
    #1;
    rst_ni = 1'b0;
    fetch_req_i = 1'b1; fetch_adr_i = 9'd20;
    #1;
    $display("mid-sweep reset wadr=%0d busy=%0b data=%010h", ram_wadr_o, busy_o, fetch_data_o);
    chk("mid_rst_wadr", 64'(ram_wadr_o), 64'd0);
    chk("mid_rst_wen", 64'(ram_wen_o), 64'h1f);
    chk("mid_rst_busy", 64'(busy_o), 64'd1);
    chk("mid_rst_data", 64'(fetch_data_o), 64'd0);
    chk("mid_rst_hit", 64'(fetch_hit_o), 64'd0);
    chk("mid_rst_fetch_gnt", 64'(fetch_gnt_o), 64'd0);
    @(posedge clk_i); #2;
    rst_ni = 1'b1;
    fetch_req_i = 1'b0;
    count_busy("mid_rst_sweep_len");
    fetch_one(9'd20, 40'h0, 1'b0);

    repeat (3) @(negedge clk_i);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
